// File: rtl/ca_scroll_buffer.sv
// ca_scroll_buffer: tear-free line store of automaton generations with optional scrolling
module ca_scroll_buffer #(
  parameter int WIDTH = 80,
  parameter int ROWS = 60,
  parameter int AW = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             scroll_en,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_row,
  input  logic [AW-1:0]    rd_col,
  output logic             rd_pixel,
  output logic [AW-1:0]    fill,
  output logic             overrun
);
  localparam int RW = $clog2(ROWS);
  localparam logic [AW-1:0] ROWS_A = AW'(ROWS);
  localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);
  localparam logic [AW:0] ROWS_S = (AW+1)'(ROWS);
  typedef enum logic [1:0] {IDLE, PEND, COMMIT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mem [ROWS];
  logic [WIDTH-1:0] stage, rd_word;
  logic [AW-1:0] wr_ptr, phys, col_idx;
  logic [AW:0] sum;
  logic rd_ok;
  always_comb begin
    state_nx = state == IDLE ? (wr_en ? PEND : IDLE) :
               state == PEND ? (frame_start ? COMMIT : PEND) :
               (wr_en ? PEND : IDLE);
  end
  // once full, scrolling puts the oldest generation (slot wr_ptr) on the top line
  always_comb begin
    sum = {1'b0, wr_ptr} + {1'b0, rd_row};
    phys = (fill == ROWS_A && scroll_en) ? (sum >= ROWS_S ? AW'(sum - ROWS_S) : sum[AW-1:0]) : rd_row;
    col_idx = WIDTH_A - 1'b1 - rd_col;
    rd_ok = rd_row < ROWS_A && rd_col < WIDTH_A && rd_row < fill;
    rd_word = mem[phys[RW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      stage <= '0;
      wr_ptr <= '0;
      fill <= '0;
      overrun <= 1'b0;
      rd_pixel <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      wr_ptr <= '0;
      fill <= '0;
      overrun <= 1'b0;
      rd_pixel <= 1'b0;
    end else begin
      state <= state_nx;
      rd_pixel <= rd_ok && rd_word[col_idx];
      if (wr_en) stage <= wr_data;
      if (state == PEND && wr_en) overrun <= 1'b1;
      if (state == COMMIT) begin
        wr_ptr <= wr_ptr == AW'(ROWS-1) ? '0 : wr_ptr + 1'b1;
        fill <= fill == ROWS_A ? fill : fill + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state == COMMIT && !clear) mem[wr_ptr[RW-1:0]] <= stage;
  end
endmodule

// File: tb/tb_ca_scroll_buffer.sv
// tb_ca_scroll_buffer: randomized and directed checks against a generation-list model
module tb_ca_scroll_buffer;
  localparam int WIDTH = 80, ROWS = 60, AW = 7;
  logic clk = 0, rst = 1, frame_start = 0, scroll_en = 0, clear = 0, wr_en = 0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [AW-1:0] rd_row = '0, rd_col = '0;
  logic rd_pixel, overrun;
  logic [AW-1:0] fill;
  int checks = 0, failures = 0;
  logic [WIDTH-1:0] gens[$];
  logic [WIDTH-1:0] stg;
  bit pend, commit, ovr;
  logic exp_pix;
  logic [7:0] b;
  always #5 clk = ~clk;
  ca_scroll_buffer #(.WIDTH(WIDTH), .ROWS(ROWS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .scroll_en(scroll_en), .clear(clear),
    .wr_en(wr_en), .wr_data(wr_data), .rd_row(rd_row), .rd_col(rd_col),
    .rd_pixel(rd_pixel), .fill(fill), .overrun(overrun));
  function automatic int mfill();
    return gens.size() > ROWS ? ROWS : gens.size();
  endfunction
  // display row r: oldest-first when scrolling a full store, else the latest generation landing in slot r
  function automatic logic pix(int r, int c);
    int n = gens.size();
    int f = mfill();
    int g;
    logic [WIDTH-1:0] w;
    if (r >= ROWS || c >= WIDTH || r >= f) return 1'b0;
    g = (f == ROWS && scroll_en) ? n - ROWS + r : r + ROWS * ((n - 1 - r) / ROWS);
    w = gens[g];
    return w[WIDTH-1-c];
  endfunction
  task automatic model_reset();
    gens.delete();
    pend = 0;
    commit = 0;
    ovr = 0;
    exp_pix = 0;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(bit we, logic [WIDTH-1:0] d, bit fs, bit clr, int r, int c);
    wr_en = we;
    wr_data = d;
    frame_start = fs;
    clear = clr;
    rd_row = r[AW-1:0];
    rd_col = c[AW-1:0];
    @(posedge clk);
    exp_pix = clr ? 1'b0 : pix(r, c);
    if (clr) begin
      gens.delete();
      pend = 0;
      commit = 0;
      ovr = 0;
    end else if (commit) begin
      gens.push_back(stg);
      commit = 0;
      pend = we;
      if (we) stg = d;
    end else if (pend) begin
      if (we) begin
        stg = d;
        ovr = 1;
      end
      if (fs) begin
        commit = 1;
        pend = 0;
      end
    end else if (we) begin
      stg = d;
      pend = 1;
    end
    @(negedge clk);
    chk("rd_pixel", rd_pixel, exp_pix);
    chk("fill", fill, mfill());
    chk("overrun", overrun, ovr);
  endtask
  task automatic idle_read();
    step(0, '0, 0, 0, $urandom_range(0, 127), $urandom_range(0, 127));
  endtask
  task automatic commit_row(logic [WIDTH-1:0] d);
    step(1, d, 0, 0, $urandom_range(0, 63), $urandom_range(0, 83));
    step(0, '0, 1, 0, $urandom_range(0, 63), $urandom_range(0, 83));
    step(0, '0, 0, 0, $urandom_range(0, 63), $urandom_range(0, 83));
  endtask
  task automatic rd_byte(input int r, output logic [7:0] v);
    for (int c = 0; c < 8; c++) begin
      step(0, '0, 0, 0, r, c);
      v[7-c] = rd_pixel;
    end
  endtask
  function automatic logic [WIDTH-1:0] tagged_row(int i);
    return {i[7:0], $urandom, $urandom, 8'($urandom)};
  endfunction
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pixel", rd_pixel, 0);
    chk("rst_fill", fill, 0);
    chk("rst_overrun", overrun, 0);
    rst = 0;
    step(0, '0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 59, 79);
    chk("rst_read_59_79", rd_pixel, 0);
    step(1, {1'b1, 79'b0}, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    chk("pend_invisible", rd_pixel, 0);
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    chk("commit_fill1", fill, 1);
    step(0, '0, 0, 0, 0, 0);
    chk("first_pixel", rd_pixel, 1);
    step(0, '0, 0, 0, 0, 1);
    chk("second_pixel", rd_pixel, 0);
    step(0, '0, 0, 1, 0, 0);
    step(1, {8'hA5, 72'h0}, 0, 0, 0, 0);
    step(1, {8'h5A, 72'h0}, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    rd_byte(0, b);
    chk("only_b_committed", b, 8'h5A);
    chk("overrun_set", overrun, 1);
    chk("overrun_fill1", fill, 1);
    step(0, '0, 0, 1, 0, 0);
    scroll_en = 1;
    for (int i = 0; i <= 60; i++) commit_row(tagged_row(i));
    chk("full_fill", fill, 60);
    rd_byte(0, b);
    chk("scroll_top", b, 1);
    rd_byte(59, b);
    chk("scroll_bottom", b, 60);
    scroll_en = 0;
    rd_byte(0, b);
    chk("wrap_row0", b, 60);
    rd_byte(1, b);
    chk("wrap_row1", b, 1);
    for (int c = 80; c < 128; c++) step(0, '0, 0, 0, 0, c);
    for (int r = 60; r < 128; r++) step(0, '0, 0, 0, r, 0);
    step(1, tagged_row(61), 0, 0, 1, 5);
    step(0, '0, 1, 0, 1, 5);
    step(0, '0, 0, 0, 1, 5);
    chk("rbw_old", rd_pixel, 0);
    step(0, '0, 0, 0, 1, 5);
    chk("rbw_new", rd_pixel, 1);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 199) == 0) scroll_en = ~scroll_en;
      step($urandom_range(0, 9) < 3, {$urandom, $urandom, 16'($urandom)}, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1499) == 0, $urandom_range(0, 70), $urandom_range(0, 90));
    end
    step(0, '0, 0, 1, 0, 0);
    for (int i = 0; i < 30; i++) commit_row(tagged_row(i));
    chk("fill30", fill, 30);
    step(1, tagged_row(99), 0, 0, 3, 3);
    step(1, tagged_row(98), 1, 1, 3, 3);
    chk("clear_fill", fill, 0);
    chk("clear_overrun", overrun, 0);
    for (int k = 0; k < 20; k++) step(0, '0, 0, 0, $urandom_range(0, 29), $urandom_range(0, 79));
    repeat (3) step(0, '0, 1, 0, 0, 0);
    chk("clear_idle", fill, 0);
    commit_row({WIDTH{1'b1}});
    step(1, {WIDTH{1'b1}}, 0, 0, 0, 0);
    step(1, {WIDTH{1'b1}}, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    chk("pre_rst_pixel", rd_pixel, 1);
    #2 rst = 1;
    #1;
    chk("async_pixel", rd_pixel, 0);
    chk("async_fill", fill, 0);
    chk("async_overrun", overrun, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 5; k++) step(0, '0, 0, 0, 0, k);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
